// File: rtl/compute_score_pkg.sv
// Shared types and constants for the chaining-score pipeline.
// Latency: n/a (package). Backpressure: n/a.
// Holds widths, score limits, stage-register structs and the exact divide-by-GAP_DIV helper.
package compute_score_pkg;

  localparam int unsigned CW      = 32;       // coordinate / W / W_avg width
  localparam int unsigned LATENCY = 4;        // register stages, input sample to result
  localparam int unsigned GAP_DIV = 100;      // 0.01 * W_avg * l
  localparam int unsigned DIFF_W  = CW + 1;   // signed coordinate difference / gap length
  localparam int unsigned PROD_W  = CW + DIFF_W;
  localparam int unsigned LG_W    = 6;

  localparam logic [CW-1:0] NEG_INF   = 32'h8000_0000;
  localparam logic [CW-1:0] SCORE_MAX = 32'h7FFF_FFFF;
  localparam logic [CW-1:0] SCORE_MIN = 32'h8000_0001;

  // Reciprocal of GAP_DIV scaled by 2^72. 72 = PROD_W + 7 bits keeps the truncation
  // error of n*RECIP/2^72 below 1 for every 65-bit n, so a single +1 fixes the quotient.
  // Valid for GAP_DIV <= 128.
  localparam int unsigned RECIP_SHIFT = PROD_W + 7;
  localparam int unsigned RECIP_W     = 66;
  localparam int unsigned FULL_W      = PROD_W + RECIP_W;
  localparam logic [RECIP_W-1:0] GAP_RECIP =
    RECIP_W'((73'd1 << RECIP_SHIFT) / 73'(GAP_DIV));

  // Stage 1: raw differences plus the operands later stages still need.
  typedef struct packed {
    logic [DIFF_W-1:0] dr;
    logic [DIFF_W-1:0] dq;
    logic [CW-1:0]     w;
    logic [CW-1:0]     w_avg;
    logic              inv;
  } s1_t;

  // Stage 2: window-clamped match length and absolute gap length.
  typedef struct packed {
    logic [CW-1:0]     alpha;
    logic [DIFF_W-1:0] l;
    logic [CW-1:0]     w_avg;
    logic              inv;
  } s2_t;

  // Stage 3: linear gap product and log term.
  typedef struct packed {
    logic [CW-1:0]     alpha;
    logic [PROD_W-1:0] prod;
    logic [LG_W-1:0]   lg;
    logic              inv;
  } s3_t;

  // Exact floor(n / GAP_DIV): reciprocal multiply underestimates by at most one.
  function automatic logic [PROD_W-1:0] div_gap(input logic [PROD_W-1:0] n);
    logic [FULL_W-1:0] full;
    logic [PROD_W-1:0] q;
    logic [PROD_W-1:0] r;
    full = FULL_W'(n) * FULL_W'(GAP_RECIP);
    q    = PROD_W'(full >> RECIP_SHIFT);
    r    = n - q * PROD_W'(GAP_DIV);
    if (r >= PROD_W'(GAP_DIV)) begin
      q = q + PROD_W'(1);
    end
    return q;
  endfunction

endpackage

// File: rtl/compute_score_if.sv
// Anchor-pair operand bus and score result for compute_score.
// Latency: n/a (interface). Backpressure: none, one pair per cycle.
// Ports: riX/riY/qiX/qiY coordinates of anchors i and j, W window, W_avg seed length, result score.
interface compute_score_if;
  import compute_score_pkg::*;

  logic [CW-1:0] riX;
  logic [CW-1:0] riY;
  logic [CW-1:0] qiX;
  logic [CW-1:0] qiY;
  logic [CW-1:0] W;
  logic [CW-1:0] W_avg;
  logic [CW-1:0] result;

  // master drives anchor pairs and consumes scores; slave is the scoring unit.
  modport master (output riX, riY, qiX, qiY, W, W_avg, input result);
  modport slave  (input riX, riY, qiX, qiY, W, W_avg, output result);

endinterface

// File: rtl/compute_score_ilog2_lod.sv
// Leading-one detector: floor(log2(in_i)) for a 33-bit value, 0 when in_i is 0.
// Latency: combinational. Backpressure: none.
// Ports: in_i 33-bit operand, lg_o 6-bit bit index of the highest set bit.
module ilog2_lod
  import compute_score_pkg::*;
(
  input  logic [DIFF_W-1:0] in_i,
  output logic [LG_W-1:0]   lg_o
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    lg_o = '0;
    for (int i = 0; i < int'(DIFF_W); i++) begin
      if (in_i[i]) begin
        lg_o = LG_W'(i);
      end
    end
  end

endmodule

// File: rtl/compute_score.sv
// Chaining score min(dr, dq, W) - gap_cost(|dr - dq|) for one anchor pair per cycle.
// Latency: 4 register stages (sampled on edge N, result valid after edge N+3). Backpressure: none.
// Ports: clk, reset (async active-low), bus (slave: anchor coordinates, W, W_avg in; result out).
module compute_score
  import compute_score_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  compute_score_if.slave bus
);

  localparam int unsigned S_W = PROD_W + 1;
  localparam logic signed [S_W-1:0] S_HI = S_W'(SCORE_MAX);
  localparam logic signed [S_W-1:0] S_LO = -S_HI;

  s1_t           s1_d, s1_q;
  s2_t           s2_d, s2_q;
  s3_t           s3_d, s3_q;
  logic [CW-1:0] result_d, result_q;

  logic [DIFF_W-1:0] diff;
  logic [CW-1:0]     dr_u, dq_u, min_rq;
  logic [LG_W-1:0]   lg;
  logic [PROD_W-1:0] gamma;
  logic signed [S_W-1:0] s;

  // Stage 1: zero-extended subtraction gives the 33-bit signed differences.
  always_comb begin
    s1_d       = '0;
    s1_d.dr    = {1'b0, bus.riX} - {1'b0, bus.riY};
    s1_d.dq    = {1'b0, bus.qiX} - {1'b0, bus.qiY};
    s1_d.w     = bus.W;
    s1_d.w_avg = bus.W_avg;
    s1_d.inv   = s1_d.dr[DIFF_W-1] | (s1_d.dr == '0) |
                 s1_d.dq[DIFF_W-1] | (s1_d.dq == '0);
  end

  // Stage 2: for valid pairs dr and dq are positive and fit in CW bits.
  always_comb begin
    s2_d       = '0;
    dr_u       = s1_q.dr[CW-1:0];
    dq_u       = s1_q.dq[CW-1:0];
    min_rq     = (dr_u < dq_u) ? dr_u : dq_u;
    diff       = s1_q.dr - s1_q.dq;
    s2_d.alpha = s1_q.inv ? '0 : ((min_rq < s1_q.w) ? min_rq : s1_q.w);
    s2_d.l     = diff[DIFF_W-1] ? (~diff + DIFF_W'(1)) : diff;
    s2_d.w_avg = s1_q.w_avg;
    s2_d.inv   = s1_q.inv;
  end

  ilog2_lod u_lod (
    .in_i (s2_q.l),
    .lg_o (lg)
  );

  // Stage 3: linear gap product and log term.
  always_comb begin
    s3_d       = '0;
    s3_d.alpha = s2_q.alpha;
    s3_d.prod  = PROD_W'(s2_q.w_avg) * PROD_W'(s2_q.l);
    s3_d.lg    = lg;
    s3_d.inv   = s2_q.inv;
  end

  // Stage 4: gap cost, subtraction and saturation. The clamp floor is SCORE_MIN,
  // so NEG_INF on the output always means an invalid pair.
  always_comb begin
    gamma = div_gap(s3_q.prod) + PROD_W'(s3_q.lg >> 1);
    s     = $signed(S_W'(s3_q.alpha)) - $signed(S_W'(gamma));
    if (s3_q.inv) begin
      result_d = NEG_INF;
    end else if (s > S_HI) begin
      result_d = SCORE_MAX;
    end else if (s < S_LO) begin
      result_d = SCORE_MIN;
    end else begin
      result_d = s[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      result_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_compute_score.sv
// Self-checking bench for compute_score: scoreboard queue filled by the driver,
// drained by a negedge monitor once each sample's result is due.
// Reference model computes the score with plain 64-bit integer arithmetic.
module tb_compute_score;
  import compute_score_pkg::*;

  logic clk = 1'b0;
  logic reset;

  compute_score_if cs_if ();

  compute_score dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cs_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    int unsigned edge_no;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned edge_cnt = 0;
  int          n_cmp    = 0;
  int          n_err    = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: result=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference score straight from the arithmetic definition.
  function automatic logic [31:0] ref_score(input logic [31:0] rx, input logic [31:0] ry,
                                             input logic [31:0] qx, input logic [31:0] qy,
                                             input logic [31:0] w,  input logic [31:0] wa);
    longint dr, dq, alpha, l, lg, s;
    longint unsigned prod, gamma;
    dr = longint'({32'd0, rx}) - longint'({32'd0, ry});
    dq = longint'({32'd0, qx}) - longint'({32'd0, qy});
    if (dr <= 0 || dq <= 0) return 32'h8000_0000;
    alpha = dr;
    if (dq < alpha) alpha = dq;
    if (longint'({32'd0, w}) < alpha) alpha = longint'({32'd0, w});
    l = (dr > dq) ? dr - dq : dq - dr;
    lg = 0;
    for (longint t = l; t > 1; t = t / 2) lg++;
    prod  = longint'({32'd0, wa}) * longint'(l);
    gamma = prod / 100 + longint'(lg / 2);
    s = alpha - longint'(gamma);
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483647) return 32'h8000_0001;
    return s[31:0];
  endfunction

  // Drive one sample for the coming rising edge and book its expected score.
  task automatic drive(input string tag,
                       input logic [31:0] rx, input logic [31:0] ry,
                       input logic [31:0] qx, input logic [31:0] qy,
                       input logic [31:0] w,  input logic [31:0] wa);
    exp_t e;
    cs_if.riX   = rx;
    cs_if.riY   = ry;
    cs_if.qiX   = qx;
    cs_if.qiY   = qy;
    cs_if.W     = w;
    cs_if.W_avg = wa;
    e.exp     = ref_score(rx, ry, qx, qy, w, wa);
    e.edge_no = edge_cnt + 1;
    e.tag     = tag;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: a sample captured on edge E is on the output after edge E+3.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].edge_no + 3 <= edge_cnt) begin
      e = sb_q.pop_front();
      check(e.tag, cs_if.result, e.exp);
    end
  end

  task automatic drive_t1(input string tag);
    drive(tag, 32'd100, 32'd30, 32'd50, 32'd20, 32'd40, 32'd40);
  endtask

  task automatic drive_t3(input string tag);
    drive(tag, 32'd80, 32'd30, 32'd70, 32'd20, 32'd40, 32'd40);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rx, ry, qx, qy, w, wa, d;
    reset       = 1'b0;
    cs_if.riX   = '0;
    cs_if.riY   = '0;
    cs_if.qiX   = '0;
    cs_if.qiY   = '0;
    cs_if.W     = '0;
    cs_if.W_avg = '0;
    repeat (3) @(negedge clk);
    check("reset_idle", cs_if.result, 32'h0);
    reset = 1'b1;

    // Directed cases.
    drive_t1("T1_nominal");
    drive("T2_window",   32'd100,   32'd30, 32'd50, 32'd20, 32'd20,  32'd40);
    drive_t3("T3_zero_gap");
    drive("T4_dq_zero",  32'd100,   32'd30, 32'd20, 32'd20, 32'd40,  32'd40);
    drive("T4_r_neg",    32'd20,    32'd30, 32'd50, 32'd20, 32'd40,  32'd40);
    drive("T5_big_gap",  32'd10000, 32'd0,  32'd10, 32'd0,  32'd100, 32'd100);
    drive("W_zero",      32'd100,   32'd30, 32'd50, 32'd20, 32'd0,   32'd40);
    drive("sat_hi",      32'hF000_0000, 32'd0, 32'hF000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5);
    drive("sat_lo",      32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'd10, 32'hFFFF_FFFF);

    // Back-to-back stream, then an asynchronous reset mid-stream.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive_t1($sformatf("T6_stream%0d", i));
      else            drive_t3($sformatf("T6_stream%0d", i));
    end
    #2;
    reset = 1'b0;
    #1;
    check("reset_async", cs_if.result, 32'h0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", cs_if.result, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i % 2 == 0) drive_t1($sformatf("T6_post%0d", i));
      else            drive_t3($sformatf("T6_post%0d", i));
      check($sformatf("post_reset_bubble%0d", i), cs_if.result, 32'h0);
    end
    for (int i = 3; i < 10; i++) begin
      if (i % 2 == 0) drive_t1($sformatf("T6_post%0d", i));
      else            drive_t3($sformatf("T6_post%0d", i));
    end

    // Randomized traffic across several operand regimes.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: begin
          ry = $urandom_range(0, 1000); rx = ry + $urandom_range(0, 2000);
          qy = $urandom_range(0, 1000); qx = qy + $urandom_range(0, 2000);
          w  = $urandom_range(0, 3000); wa = $urandom_range(0, 200);
        end
        1: begin
          rx = $urandom; ry = $urandom; qx = $urandom; qy = $urandom;
          w  = $urandom; wa = $urandom;
        end
        2: begin
          rx = $urandom | 32'h8000_0000; ry = 32'd0;
          qx = $urandom_range(1, 100);   qy = 32'd0;
          w  = $urandom; wa = 32'hFFFF_FFFF - $urandom_range(0, 1000);
        end
        3: begin
          d  = $urandom | 32'h8000_0000;
          ry = $urandom_range(0, 100); qy = $urandom_range(0, 100);
          rx = ry + d; qx = qy + d + $urandom_range(0, 3);
          w  = 32'hFFFF_FFFF; wa = $urandom_range(0, 50);
        end
        default: begin
          rx = $urandom_range(0, 5000); ry = rx + $urandom_range(0, 10);
          qx = $urandom_range(0, 5000); qy = $urandom_range(0, 5000);
          w  = $urandom; wa = $urandom;
        end
      endcase
      drive($sformatf("rand%0d", i), rx, ry, qx, qy, w, wa);
    end

    repeat (6) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
